// File: rtl/bp_pkg.sv
// Shared constants and types for the branch target predictor:
// default table size, 2-bit counter encodings and the BTB entry layout.
package bp_pkg;

  localparam int BP_ENTRIES = 64;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  // Tag field is sized for the smallest table; narrower tags are zero-extended.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
  } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for a 2-bit saturating branch-history counter.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] nxt
);

  // Step toward taken or not-taken, holding at the ends of the range.
  always_comb begin
    nxt = cnt;
    if (inc && (cnt != STRONG_T)) begin
      nxt = cnt + 2'd1;
    end else if (dec && (cnt != STRONG_NT)) begin
      nxt = cnt - 2'd1;
    end else begin
      nxt = cnt;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB plus 2-bit BHT: zero-latency fetch lookup, EX-stage training,
// mispredict/redirect generation and saturating statistics. Optional macro: GSHARE_EN.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = BP_ENTRIES,
  localparam int INDEX_W = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        PC_F,
  output logic               BP_en_F,
  output logic               BP_decision_F,
  output logic [31:0]        BP_target_F,
  output logic [INDEX_W-1:0] BP_index_F,
  input  logic               upd_valid_EX,
  input  logic [31:0]        upd_PC_EX,
  input  logic               upd_taken_EX,
  input  logic [31:0]        upd_target_EX,
  input  logic [INDEX_W-1:0] upd_index_EX,
  input  logic               BP_en_EX,
  input  logic               BP_decision_EX,
  input  logic [31:0]        pred_target_EX,
  output logic               mispredict_EX,
  output logic [31:0]        redirect_PC_EX,
  output logic [31:0]        branch_count,
  output logic [31:0]        mispredict_count
);

  btb_entry_t         btb_r [ENTRIES];
  logic [1:0]         bht_r [ENTRIES];
  logic [INDEX_W-1:0] btb_idx_s;
  logic [INDEX_W-1:0] upd_idx_s;
  logic [29:0]        fetch_tag_s;
  logic [29:0]        upd_tag_s;
  logic               hit_s;
  logic               upd_hit_s;
  logic               predicted_s;
  logic [1:0]         cnt_nxt_s;
  logic               unused_pc_bits_s;

  assign btb_idx_s        = PC_F[INDEX_W+1:2];
  assign upd_idx_s        = upd_PC_EX[INDEX_W+1:2];
  assign fetch_tag_s      = 30'(PC_F[31 -: TAG_W]);
  assign upd_tag_s        = 30'(upd_PC_EX[31 -: TAG_W]);
  assign unused_pc_bits_s = ^PC_F[1:0];

`ifdef GSHARE_EN
  logic [INDEX_W-1:0] ghr_r;

  assign BP_index_F = btb_idx_s ^ ghr_r;

  // Global history advances only on resolved branches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_r <= '0;
    end else if (upd_valid_EX) begin
      ghr_r <= {ghr_r[INDEX_W-2:0], upd_taken_EX};
    end
  end
`else
  assign BP_index_F = btb_idx_s;
`endif

  // Fetch lookup; reads pre-update table contents.
  always_comb begin
    hit_s         = btb_r[btb_idx_s].valid && (btb_r[btb_idx_s].tag == fetch_tag_s);
    BP_en_F       = hit_s;
    BP_decision_F = hit_s & bht_r[BP_index_F][1];
    if (hit_s) begin
      BP_target_F = btb_r[btb_idx_s].target;
    end else begin
      BP_target_F = 32'd0;
    end
  end

  // EX resolution: compare actual outcome with the prediction carried down the pipe.
  always_comb begin
    predicted_s = BP_en_EX & BP_decision_EX;
    upd_hit_s   = btb_r[upd_idx_s].valid && (btb_r[upd_idx_s].tag == upd_tag_s);
    if (upd_valid_EX) begin
      mispredict_EX = (upd_taken_EX != predicted_s) |
                      (upd_taken_EX & predicted_s & (upd_target_EX != pred_target_EX));
      if (upd_taken_EX) begin
        redirect_PC_EX = upd_target_EX;
      end else begin
        redirect_PC_EX = upd_PC_EX + 32'd4;
      end
    end else begin
      mispredict_EX  = 1'b0;
      redirect_PC_EX = 32'd0;
    end
  end

  sat_counter2 u_bht_cnt (
    .cnt (bht_r[upd_index_EX]),
    .inc (upd_taken_EX),
    .dec (!upd_taken_EX),
    .nxt (cnt_nxt_s)
  );

  // Table training; a taken miss allocates with a weakly-taken counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_r[i] <= '0;
        bht_r[i] <= WEAK_NT;
      end
    end else if (upd_valid_EX) begin
      if (upd_hit_s) begin
        bht_r[upd_index_EX] <= cnt_nxt_s;
        if (upd_taken_EX) begin
          btb_r[upd_idx_s].target <= upd_target_EX;
        end
      end else if (upd_taken_EX) begin
        btb_r[upd_idx_s]    <= '{valid: 1'b1, tag: upd_tag_s, target: upd_target_EX};
        bht_r[upd_index_EX] <= WEAK_T;
      end
    end
  end

  // Saturating statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else if (upd_valid_EX) begin
      if (branch_count != 32'hFFFF_FFFF) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict_EX && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor (ENTRIES=64, default build).
module tb_branch_target_predictor;

  localparam int IW = 6;

  logic          clk;
  logic          rst;
  logic [31:0]   PC_F;
  logic          BP_en_F;
  logic          BP_decision_F;
  logic [31:0]   BP_target_F;
  logic [IW-1:0] BP_index_F;
  logic          upd_valid_EX;
  logic [31:0]   upd_PC_EX;
  logic          upd_taken_EX;
  logic [31:0]   upd_target_EX;
  logic [IW-1:0] upd_index_EX;
  logic          BP_en_EX;
  logic          BP_decision_EX;
  logic [31:0]   pred_target_EX;
  logic          mispredict_EX;
  logic [31:0]   redirect_PC_EX;
  logic [31:0]   branch_count;
  logic [31:0]   mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_target_predictor #(.ENTRIES(64)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC_F             (PC_F),
    .BP_en_F          (BP_en_F),
    .BP_decision_F    (BP_decision_F),
    .BP_target_F      (BP_target_F),
    .BP_index_F       (BP_index_F),
    .upd_valid_EX     (upd_valid_EX),
    .upd_PC_EX        (upd_PC_EX),
    .upd_taken_EX     (upd_taken_EX),
    .upd_target_EX    (upd_target_EX),
    .upd_index_EX     (upd_index_EX),
    .BP_en_EX         (BP_en_EX),
    .BP_decision_EX   (BP_decision_EX),
    .pred_target_EX   (pred_target_EX),
    .mispredict_EX    (mispredict_EX),
    .redirect_PC_EX   (redirect_PC_EX),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic en, input logic dec, input logic [31:0] ptgt);
    upd_valid_EX   = 1'b1;
    upd_PC_EX      = pc;
    upd_taken_EX   = taken;
    upd_target_EX  = tgt;
    upd_index_EX   = pc[IW+1:2];
    BP_en_EX       = en;
    BP_decision_EX = dec;
    pred_target_EX = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid_EX   = 1'b0;
    upd_PC_EX      = 32'd0;
    upd_taken_EX   = 1'b0;
    upd_target_EX  = 32'd0;
    upd_index_EX   = '0;
    BP_en_EX       = 1'b0;
    BP_decision_EX = 1'b0;
    pred_target_EX = 32'd0;
  endtask

  task automatic look(input logic [31:0] pc, input logic en, input logic dec,
                      input logic [31:0] tgt, input string tag);
    PC_F = pc;
    #1;
    chk({tag, "_en"},  32'(BP_en_F),       32'(en));
    chk({tag, "_dec"}, 32'(BP_decision_F), 32'(dec));
    chk({tag, "_tgt"}, BP_target_F,        tgt);
  endtask

  task automatic resolve(input logic mp, input logic [31:0] rpc, input string tag);
    chk({tag, "_mp"},  32'(mispredict_EX), 32'(mp));
    chk({tag, "_rpc"}, redirect_PC_EX,     rpc);
  endtask

  initial begin
    rst  = 1'b0;
    PC_F = 32'h100;
    idle();
    #12;
    look(32'h100, 1'b0, 1'b0, 32'h0, "rst_look");
    chk("rst_bcnt", branch_count, 32'd0);
    chk("rst_mcnt", mispredict_count, 32'd0);
    resolve(1'b0, 32'h0, "rst_res");
`ifndef GSHARE_EN
    chk("rst_idx", 32'(BP_index_F), 32'd0);
`endif
    rst = 1'b1;
    step();

    // Allocate 0x100 -> 0x200; same-cycle lookup still misses.
    upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 32'h200, "alloc");
    look(32'h100, 1'b0, 1'b0, 32'h0, "nobypass");
    step();
    idle();
    look(32'h100, 1'b1, 1'b1, 32'h200, "after_alloc");
    chk("bcnt1", branch_count, 32'd1);
    chk("mcnt1", mispredict_count, 32'd1);

    // Not-taken training: counter 2 -> 1 -> 0 -> 0.
    upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
    resolve(1'b1, 32'h104, "nt1");
    step();
    idle();
    look(32'h100, 1'b1, 1'b0, 32'h200, "nt1_look");
    upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200);
    resolve(1'b0, 32'h104, "nt2");
    step();
    upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h200);
    resolve(1'b0, 32'h104, "nt3");
    step();
    idle();
    look(32'h100, 1'b1, 1'b0, 32'h200, "nt3_look");
    chk("bcnt4", branch_count, 32'd4);
    chk("mcnt2", mispredict_count, 32'd2);

    // Wrong target on a correctly predicted taken branch; counter 0 -> 1.
    upd(32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 32'h200);
    resolve(1'b1, 32'h300, "badtgt");
    step();
    idle();
    look(32'h100, 1'b1, 1'b0, 32'h300, "badtgt_look");
    // Counter 1 -> 2 -> 3 -> 3, then one not-taken back to 2.
    upd(32'h100, 1'b1, 32'h300, 1'b1, 1'b0, 32'h300);
    resolve(1'b1, 32'h300, "t_predn");
    step();
    upd(32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
    resolve(1'b0, 32'h300, "t_ok1");
    step();
    upd(32'h100, 1'b1, 32'h300, 1'b1, 1'b1, 32'h300);
    resolve(1'b0, 32'h300, "t_ok2");
    step();
    upd(32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300);
    resolve(1'b1, 32'h104, "sat_nt");
    step();
    idle();
    look(32'h100, 1'b1, 1'b1, 32'h300, "sat_look");
    chk("bcnt9", branch_count, 32'd9);
    chk("mcnt5", mispredict_count, 32'd5);

    // Aliasing: 0x200 shares index 0 with 0x100.
    look(32'h200, 1'b0, 1'b0, 32'h0, "alias_miss");
    upd(32'h200, 1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
    resolve(1'b1, 32'h400, "alias_upd");
    step();
    idle();
    look(32'h200, 1'b1, 1'b1, 32'h400, "alias_hit");
    look(32'h100, 1'b0, 1'b0, 32'h0, "alias_evict");

    // Not-taken miss changes nothing; redirect is fall-through.
    upd(32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 32'h108, "ntmiss");
    step();
    idle();
    look(32'h104, 1'b0, 1'b0, 32'h0, "ntmiss_look");

    // Fall-through wraps to zero.
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    resolve(1'b0, 32'h0, "wrap");
    step();
    idle();
    chk("bcnt12", branch_count, 32'd12);
    chk("mcnt6", mispredict_count, 32'd6);

    // Invalid update keeps outputs quiet regardless of other inputs.
    upd_PC_EX      = 32'h1234;
    upd_taken_EX   = 1'b1;
    upd_target_EX  = 32'h5678;
    BP_en_EX       = 1'b1;
    #1;
    resolve(1'b0, 32'h0, "novalid");
    step();
    idle();
    chk("bcnt_hold", branch_count, 32'd12);

    // Asynchronous reset between edges clears tables and counters immediately.
    #2;
    rst = 1'b0;
    #1;
    look(32'h200, 1'b0, 1'b0, 32'h0, "arst_look");
    chk("arst_bcnt", branch_count, 32'd0);
    chk("arst_mcnt", mispredict_count, 32'd0);
    rst = 1'b1;
    step();

`ifdef GSHARE_EN
    upd(32'h100, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
    step();
    upd(32'h100, 1'b1, 32'h200, 1'b1, 1'b1, 32'h200);
    step();
    idle();
    PC_F = 32'h100;
    #1;
    chk("gshare_idx", 32'(BP_index_F), 32'h3);
`else
    PC_F = 32'h100;
    #1;
    chk("pc_idx", 32'(BP_index_F), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Fetch-side producer of BP_en_F / BP_decision_F carried down the pipeline by the decode and execute registers; also the consumer of those bits when the branch resolves in EX.
- Holds a direct-mapped BTB (valid, tag, target) and a 2-bit saturating-counter BHT.
- Answers a fetch lookup in the same cycle and trains on EX resolution.
- Raises a mispredict/redirect request for the hazard unit, and keeps saturating branch/mispredict statistics.

Parameters:
- ENTRIES, 64, number of BTB/BHT entries; power of two, minimum 4.
- INDEX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-INDEX_W, tag width, taken from PC[31:2+INDEX_W].

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- PC_F  in  32  fetch PC
- BP_en_F  out  1  BTB hit for PC_F
- BP_decision_F  out  1  predicted taken; meaningful only when BP_en_F=1
- BP_target_F  out  32  predicted target
- BP_index_F  out  INDEX_W  BHT index used for this lookup; travels with the instruction
- upd_valid_EX  in  1  a conditional branch resolves in EX this cycle
- upd_PC_EX  in  32  PC of the resolving branch
- upd_taken_EX  in  1  actual outcome
- upd_target_EX  in  32  actual taken target
- upd_index_EX  in  INDEX_W  BP_index_F value carried with the branch
- BP_en_EX  in  1  prediction-valid bit carried with the branch
- BP_decision_EX  in  1  prediction bit carried with the branch
- pred_target_EX  in  32  BP_target_F value carried with the branch
- mispredict_EX  out  1  redirect/flush request to the hazard unit
- redirect_PC_EX  out  32  correct next PC
- branch_count  out  32  resolved-branch count, saturating
- mispredict_count  out  32  mispredict count, saturating

Behaviour:
- Reset: all valid bits 0, all BHT counters 2'b01, statistics counters 0. BP_en_F=0, BP_decision_F=0, BP_target_F=0, mispredict_EX=0, redirect_PC_EX=0.
- Lookup is combinational and has zero latency.
  - btb_idx = PC_F[INDEX_W+1:2]; BP_index_F = btb_idx (see the optional feature for the alternative).
  - hit = valid[btb_idx] && tag[btb_idx] == PC_F[31:2+INDEX_W].
  - BP_en_F = hit; BP_decision_F = hit & bht[BP_index_F][1]; BP_target_F = hit ? target[btb_idx] : 0.
- Resolution is combinational and is only asserted when upd_valid_EX=1.
  - predicted = BP_en_EX & BP_decision_EX.
  - mispredict_EX = (upd_taken_EX != predicted) | (upd_taken_EX & predicted & (upd_target_EX != pred_target_EX)).
  - redirect_PC_EX = upd_taken_EX ? upd_target_EX : upd_PC_EX + 4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
  - When upd_valid_EX=0: mispredict_EX=0 and redirect_PC_EX=0.
- Training happens at the posedge on which upd_valid_EX=1.
  - BTB hit at the update PC: BHT counter at upd_index_EX increments if taken, decrements if not, saturating at 3 and 0. If taken, the target is overwritten with upd_target_EX.
  - BTB miss and taken: allocate the entry (valid=1, tag, target) and set the BHT counter at upd_index_EX to 2'b10.
  - BTB miss and not-taken: no state change.
- Statistics at the same posedge: branch_count increments; mispredict_count increments when mispredict_EX=1. Both hold at 0xFFFFFFFF.
- Same-cycle read/write to one entry: the lookup sees pre-update contents. There is no bypass.
- Asynchronous reset mid-operation clears the tables immediately; an update in flight is lost.
- The table holds no stall input. The pipeline registers hold the carried fields.

Optional Feature:
- GSHARE_EN defined:
  - Adds an INDEX_W-bit global history register, reset 0.
  - BP_index_F = PC_F[INDEX_W+1:2] ^ ghr. The BTB tag/target stay PC-indexed.
  - When upd_valid_EX=1, ghr <= {ghr[INDEX_W-2:0], upd_taken_EX}, updated non-speculatively.
- GSHARE_EN undefined: no history register; BP_index_F equals btb_idx.

Decomposition:
- Package bp_pkg: BP_ENTRIES default constant; counter encodings STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3; the btb_entry_t struct {valid, tag, target}.
- One sub-module, sat_counter2: 2-bit saturating next-state logic (inc/dec, saturate), instantiated per update path.

Test Plan:
- Reset, then PC_F=0x100 → BP_en_F=0, BP_decision_F=0, BP_target_F=0; both statistics counters read 0.
- Update PC 0x100, taken, target 0x200, BP_en_EX=0 → mispredict_EX=1, redirect_PC_EX=0x200. Next cycle, lookup 0x100 → BP_en_F=1, BP_decision_F=1, BP_target_F=0x200.
- Three not-taken updates at 0x100 with carried prediction taken → counter goes 2→1→0 and BP_decision_F=0; each mispredict_EX=1 with redirect_PC_EX=0x104 (the update after the counter reaches 1 carries prediction 0 and gives mispredict_EX=0); mispredict_count increments accordingly.
- Aliasing: allocate 0x100, then look up 0x100+4*ENTRIES → BP_en_F=0 (tag mismatch); a taken update there replaces the entry, and 0x100 then misses.
- Taken update with BP_en_EX=1, BP_decision_EX=1, pred_target 0x200, actual 0x300 → mispredict_EX=1, redirect_PC_EX=0x300; the stored target becomes 0x300.
- GSHARE_EN: taken updates shift ghr 0→1→3; for PC 0x100 with ENTRIES=64, BP_index_F = 0x00^0x03 = 0x03. With the macro undefined, BP_index_F=0x00.
